// File: rtl/sync_fifo_thresh.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_thresh
// Purpose  : Single-clock FIFO with occupancy count, almost-full/almost-empty
//            thresholds and registered read data. Define SYNC_FIFO_ERR_EN to
//            enable sticky overflow/underflow flags.
// Revision : 1.0  initial release
// ============================================================================
module sync_fifo_thresh #(
  parameter int DATA_BITS     = 10,
  parameter int FIFO_LENGTH   = 16,
  parameter int ADDR_BIT      = $clog2(FIFO_LENGTH),
  parameter int AFULL_THRESH  = 12,
  parameter int AEMPTY_THRESH = 4,
  parameter int RESET_VALUE   = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 write,
  input  logic [DATA_BITS-1:0] input_data,
  output logic                 full,
  output logic                 almost_full,
  input  logic                 read,
  output logic [DATA_BITS-1:0] output_data,
  output logic                 output_valid,
  output logic                 empty,
  output logic                 almost_empty,
  output logic [ADDR_BIT:0]    count,
  output logic                 overflow,
  output logic                 underflow,
  input  logic                 err_clear
);

  localparam logic [ADDR_BIT:0] DEPTH_C  = (ADDR_BIT+1)'(FIFO_LENGTH);
  localparam logic [ADDR_BIT:0] AFULL_C  = (ADDR_BIT+1)'(AFULL_THRESH);
  localparam logic [ADDR_BIT:0] AEMPTY_C = (ADDR_BIT+1)'(AEMPTY_THRESH);
  localparam logic [ADDR_BIT:0] ONE_C    = (ADDR_BIT+1)'(1);
  localparam logic              RST_LEVEL = (RESET_VALUE != 0);

  logic [DATA_BITS-1:0] storage_q [FIFO_LENGTH];

  logic [ADDR_BIT:0]    wr_ptr_q, wr_ptr_d;
  logic [ADDR_BIT:0]    rd_ptr_q, rd_ptr_d;
  logic [ADDR_BIT:0]    count_q, count_d;
  logic                 full_q, full_d;
  logic                 empty_q, empty_d;
  logic                 almost_full_q, almost_full_d;
  logic                 almost_empty_q, almost_empty_d;
  logic [DATA_BITS-1:0] output_data_q, output_data_d;
  logic                 output_valid_q, output_valid_d;

  logic wr_acc;
  logic rd_acc;

  // Acceptance uses the registered flags, so a full FIFO never takes a write
  // even when a read frees a slot in the same cycle.
  assign wr_acc = write & ~full_q;
  assign rd_acc = read & ~empty_q;

  always_comb begin
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    output_data_d  = output_data_q;
    output_valid_d = 1'b0;

    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + ONE_C;
    end
    if (rd_acc) begin
      rd_ptr_d       = rd_ptr_q + ONE_C;
      output_data_d  = storage_q[rd_ptr_q[ADDR_BIT-1:0]];
      output_valid_d = 1'b1;
    end

    if (wr_acc && !rd_acc) begin
      count_d = count_q + ONE_C;
    end else if (rd_acc && !wr_acc) begin
      count_d = count_q - ONE_C;
    end

    full_d         = (count_d == DEPTH_C);
    empty_d        = (count_d == '0);
    almost_full_d  = (count_d >= AFULL_C);
    almost_empty_d = (count_d <= AEMPTY_C);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (reset == RST_LEVEL) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      full_q         <= 1'b0;
      empty_q        <= 1'b1;
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
      output_data_q  <= '0;
      output_valid_q <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      full_q         <= full_d;
      empty_q        <= empty_d;
      almost_full_q  <= almost_full_d;
      almost_empty_q <= almost_empty_d;
      output_data_q  <= output_data_d;
      output_valid_q <= output_valid_d;
    end
  end

  // Storage is intentionally left out of reset.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      storage_q[wr_ptr_q[ADDR_BIT-1:0]] <= input_data;
    end
  end

  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = almost_full_q;
  assign almost_empty = almost_empty_q;
  assign count        = count_q;
  assign output_data  = output_data_q;
  assign output_valid = output_valid_q;

`ifdef SYNC_FIFO_ERR_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  // Set has priority over err_clear so an error in the clearing cycle is kept.
  always_comb begin
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (err_clear) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (write && full_q) begin
      overflow_d = 1'b1;
    end
    if (read && empty_q) begin
      underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (reset == RST_LEVEL) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`else
  logic unused_err_clear;
  assign unused_err_clear = err_clear;
  assign overflow         = 1'b0;
  assign underflow        = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_thresh.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_fifo_thresh
// Purpose  : Directed self-checking bench for sync_fifo_thresh (default
//            parameters; error-flag expectations follow SYNC_FIFO_ERR_EN).
// Revision : 1.0  initial release
// ============================================================================
module tb_sync_fifo_thresh;

`ifdef SYNC_FIFO_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       write = 1'b0;
  logic       read = 1'b0;
  logic       err_clear = 1'b0;
  logic [9:0] input_data = '0;

  logic       full, almost_full, empty, almost_empty;
  logic       output_valid, overflow, underflow;
  logic [9:0] output_data;
  logic [4:0] count;

  int n_cmp = 0;
  int n_bad = 0;

  sync_fifo_thresh dut (
    .clk          (clk),
    .reset        (reset),
    .write        (write),
    .input_data   (input_data),
    .full         (full),
    .almost_full  (almost_full),
    .read         (read),
    .output_data  (output_data),
    .output_valid (output_valid),
    .empty        (empty),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow),
    .err_clear    (err_clear)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [9:0] base, input int n);
    for (int k = 0; k < n; k++) begin
      write      = 1'b1;
      input_data = base + 10'(k);
      step();
    end
    write = 1'b0;
  endtask

  task automatic drain(input int n);
    for (int k = 0; k < n; k++) begin
      read = 1'b1;
      step();
    end
    read = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step();
    step();
    n_cmp++;
    if ({full, almost_full, empty, almost_empty} !== 4'b0011) begin
      n_bad++;
      $display("FAIL reset_flags: got f/af/e/ae=%b want 0011", {full, almost_full, empty, almost_empty});
    end
    n_cmp++;
    if ({count, output_valid, output_data, overflow, underflow} !== {5'd0, 1'b0, 10'h000, 2'b00}) begin
      n_bad++;
      $display("FAIL reset_state: got cnt=%0d v=%b d=%h ovf=%b udf=%b want 0 0 000 0 0",
               count, output_valid, output_data, overflow, underflow);
    end
    reset = 1'b1;
    step();
  endtask

  task automatic test_fill_drain();
    logic [3:0] ef;
    for (int i = 1; i <= 16; i++) begin
      write      = 1'b1;
      input_data = 10'(i);
      step();
      ef = {(i == 16), (i >= 12), 1'b0, (i <= 4)};
      n_cmp++;
      if ({count, full, almost_full, empty, almost_empty} !== {5'(i), ef}) begin
        n_bad++;
        $display("FAIL fill_w%0d: got cnt=%0d f/af/e/ae=%b want cnt=%0d %b",
                 i, count, {full, almost_full, empty, almost_empty}, i, ef);
      end
    end
    write = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      read = 1'b1;
      step();
      n_cmp++;
      if ({output_valid, output_data, count} !== {1'b1, 10'(i), 5'(16 - i)}) begin
        n_bad++;
        $display("FAIL drain_r%0d: got v=%b d=%h cnt=%0d want v=1 d=%h cnt=%0d",
                 i, output_valid, output_data, count, 10'(i), 16 - i);
      end
    end
    read = 1'b0;
    n_cmp++;
    if ({empty, almost_empty, full} !== 3'b110) begin
      n_bad++;
      $display("FAIL drain_empty: got e/ae/f=%b want 110", {empty, almost_empty, full});
    end
    step();
    n_cmp++;
    if ({output_valid, output_data} !== {1'b0, 10'h010}) begin
      n_bad++;
      $display("FAIL drain_hold: got v=%b d=%h want v=0 d=010", output_valid, output_data);
    end
  endtask

  task automatic test_full_write_read();
    fill(10'h001, 16);
    n_cmp++;
    if ({full, count} !== {1'b1, 5'd16}) begin
      n_bad++;
      $display("FAIL fwr_full: got f=%b cnt=%0d want f=1 cnt=16", full, count);
    end
    write      = 1'b1;
    read       = 1'b1;
    input_data = 10'h3FF;
    step();
    write = 1'b0;
    read  = 1'b0;
    n_cmp++;
    if ({count, full, output_valid, output_data, overflow} !== {5'd15, 1'b0, 1'b1, 10'h001, ERR_EN}) begin
      n_bad++;
      $display("FAIL fwr_both: got cnt=%0d f=%b v=%b d=%h ovf=%b want 15 0 1 001 %b",
               count, full, output_valid, output_data, overflow, ERR_EN);
    end
    for (int i = 2; i <= 16; i++) begin
      read = 1'b1;
      step();
      n_cmp++;
      if ({output_valid, output_data} !== {1'b1, 10'(i)}) begin
        n_bad++;
        $display("FAIL fwr_drain%0d: got v=%b d=%h want v=1 d=%h", i, output_valid, output_data, 10'(i));
      end
    end
    read = 1'b0;
    n_cmp++;
    if ({empty, count} !== {1'b1, 5'd0}) begin
      n_bad++;
      $display("FAIL fwr_no3ff: got e=%b cnt=%0d want e=1 cnt=0", empty, count);
    end
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
  endtask

  task automatic test_empty_write_read();
    write      = 1'b1;
    read       = 1'b1;
    input_data = 10'h155;
    step();
    write = 1'b0;
    read  = 1'b0;
    n_cmp++;
    if ({count, output_valid, empty, underflow} !== {5'd1, 1'b0, 1'b0, ERR_EN}) begin
      n_bad++;
      $display("FAIL ewr_both: got cnt=%0d v=%b e=%b udf=%b want 1 0 0 %b",
               count, output_valid, empty, underflow, ERR_EN);
    end
    read = 1'b1;
    step();
    read = 1'b0;
    n_cmp++;
    if ({output_valid, output_data, empty} !== {1'b1, 10'h155, 1'b1}) begin
      n_bad++;
      $display("FAIL ewr_read: got v=%b d=%h e=%b want v=1 d=155 e=1", output_valid, output_data, empty);
    end
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
  endtask

  task automatic test_stream();
    int wi;
    int ri;
    fill(10'h100, 3);
    wi = 3;
    ri = 0;
    for (int c = 0; c < 37; c++) begin
      write      = 1'b1;
      read       = 1'b1;
      input_data = 10'h100 + 10'(wi);
      step();
      n_cmp++;
      if ({output_valid, output_data, count} !== {1'b1, 10'h100 + 10'(ri), 5'd3}) begin
        n_bad++;
        $display("FAIL stream_%0d: got v=%b d=%h cnt=%0d want v=1 d=%h cnt=3",
                 ri, output_valid, output_data, count, 10'h100 + 10'(ri));
      end
      wi++;
      ri++;
    end
    write = 1'b0;
    while (ri < 40) begin
      read = 1'b1;
      step();
      n_cmp++;
      if ({output_valid, output_data} !== {1'b1, 10'h100 + 10'(ri)}) begin
        n_bad++;
        $display("FAIL stream_tail%0d: got v=%b d=%h want v=1 d=%h",
                 ri, output_valid, output_data, 10'h100 + 10'(ri));
      end
      ri++;
    end
    read = 1'b0;
    n_cmp++;
    if ({empty, count} !== {1'b1, 5'd0}) begin
      n_bad++;
      $display("FAIL stream_end: got e=%b cnt=%0d want e=1 cnt=0", empty, count);
    end
  endtask

  task automatic test_errors();
    read = 1'b1;
    step();
    read = 1'b0;
    n_cmp++;
    if ({underflow, overflow, count, output_valid} !== {ERR_EN, 1'b0, 5'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL err_udf: got udf=%b ovf=%b cnt=%0d v=%b want %b 0 0 0",
               underflow, overflow, count, output_valid, ERR_EN);
    end
    fill(10'h300, 16);
    write = 1'b1;
    step();
    write = 1'b0;
    n_cmp++;
    if ({overflow, underflow, count} !== {ERR_EN, ERR_EN, 5'd16}) begin
      n_bad++;
      $display("FAIL err_ovf: got ovf=%b udf=%b cnt=%0d want %b %b 16", overflow, underflow, count, ERR_EN, ERR_EN);
    end
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    n_cmp++;
    if ({overflow, underflow} !== 2'b00) begin
      n_bad++;
      $display("FAIL err_clear: got ovf=%b udf=%b want 0 0", overflow, underflow);
    end
    drain(16);
    read      = 1'b1;
    err_clear = 1'b1;
    step();
    read = 1'b0;
    n_cmp++;
    if ({underflow, overflow} !== {ERR_EN, 1'b0}) begin
      n_bad++;
      $display("FAIL err_setwins: got udf=%b ovf=%b want %b 0", underflow, overflow, ERR_EN);
    end
    step();
    err_clear = 1'b0;
    n_cmp++;
    if (underflow !== 1'b0) begin
      n_bad++;
      $display("FAIL err_clear2: got udf=%b want 0", underflow);
    end
  endtask

  task automatic test_reset_mid();
    fill(10'h200, 8);
    read = 1'b1;
    step();
    read = 1'b0;
    n_cmp++;
    if ({count, output_valid, output_data} !== {5'd7, 1'b1, 10'h200}) begin
      n_bad++;
      $display("FAIL rmid_pre: got cnt=%0d v=%b d=%h want 7 1 200", count, output_valid, output_data);
    end
    #3;
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({count, empty, almost_empty, full, output_valid, output_data} !== {5'd0, 3'b110, 1'b0, 10'h000}) begin
      n_bad++;
      $display("FAIL rmid_async: got cnt=%0d e/ae/f=%b v=%b d=%h want 0 110 0 000",
               count, {empty, almost_empty, full}, output_valid, output_data);
    end
    step();
    #2;
    reset = 1'b1;
    step();
    fill(10'h2A0, 3);
    n_cmp++;
    if ({count, empty} !== {5'd3, 1'b0}) begin
      n_bad++;
      $display("FAIL rmid_refill: got cnt=%0d e=%b want 3 0", count, empty);
    end
    for (int k = 0; k < 3; k++) begin
      read = 1'b1;
      step();
      n_cmp++;
      if ({output_valid, output_data} !== {1'b1, 10'h2A0 + 10'(k)}) begin
        n_bad++;
        $display("FAIL rmid_read%0d: got v=%b d=%h want v=1 d=%h", k, output_valid, output_data, 10'h2A0 + 10'(k));
      end
    end
    read = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_fill_drain();
    test_full_write_read();
    test_empty_write_read();
    test_stream();
    test_errors();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
